// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - control unit opcodes, FSM state codes, select codes and strobe bundle
package cu_pkg;

  localparam int ST_W = 5;

  localparam logic [ST_W-1:0] S_FETCH1 = 5'd0;
  localparam logic [ST_W-1:0] S_FETCH2 = 5'd1;
  localparam logic [ST_W-1:0] S_FETCH3 = 5'd2;
  localparam logic [ST_W-1:0] S_FETCH4 = 5'd3;
  localparam logic [ST_W-1:0] S_LDAC1  = 5'd4;
  localparam logic [ST_W-1:0] S_LDAC2  = 5'd5;
  localparam logic [ST_W-1:0] S_LDAC3  = 5'd6;
  localparam logic [ST_W-1:0] S_LDAC4  = 5'd7;
  localparam logic [ST_W-1:0] S_LDAC5  = 5'd8;
  localparam logic [ST_W-1:0] S_LDAC6  = 5'd9;
  localparam logic [ST_W-1:0] S_LDAC7  = 5'd10;
  localparam logic [ST_W-1:0] S_STAC1  = 5'd11;
  localparam logic [ST_W-1:0] S_STAC2  = 5'd12;
  localparam logic [ST_W-1:0] S_STAC3  = 5'd13;
  localparam logic [ST_W-1:0] S_STAC4  = 5'd14;
  localparam logic [ST_W-1:0] S_STAC5  = 5'd15;
  localparam logic [ST_W-1:0] S_STAC6  = 5'd16;
  localparam logic [ST_W-1:0] S_ADD1   = 5'd17;
  localparam logic [ST_W-1:0] S_ADD2   = 5'd18;
  localparam logic [ST_W-1:0] S_JMP1   = 5'd19;
  localparam logic [ST_W-1:0] S_JMP2   = 5'd20;
  localparam logic [ST_W-1:0] S_HALT   = 5'd21;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDAC = 8'h01;
  localparam logic [7:0] OP_STAC = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_JMPZ = 8'h04;
  localparam logic [7:0] OP_JMPN = 8'h05;
  localparam logic [7:0] OP_HALT = 8'hFF;

  localparam logic [3:0] MUXA_SEL1 = 4'b0001;
  localparam logic [3:0] MUXA_SEL2 = 4'b0010;
  localparam logic [1:0] MUXB_SEL1 = 2'b01;
  localparam logic [1:0] MUXB_SEL2 = 2'b10;
  localparam logic [3:0] ALU_PASS  = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_CAT   = 4'b1101;

  typedef struct packed {
    logic inc_pc;
    logic write_pc;
    logic write_iar;
    logic inc_iar;
    logic write_idr;
    logic write_ir;
    logic write_tr;
    logic write_mar;
    logic write_dram;
    logic off_dram;
    logic write1_mdr;
    logic write2_mdr;
    logic write_ac;
  } strobe_t;

endpackage

// File: rtl/cu_decode.sv
// rtl/cu_decode.sv - state to control-word decode; strobes gated by step, selects are not
module cu_decode
  import cu_pkg::*;
#(
  parameter int MUXA_W = 4,
  parameter int MUXB_W = 2,
  parameter int ALU_W  = 4
) (
  input  logic [ST_W-1:0]   state,
  input  logic              taken,
  input  logic              step,
  output strobe_t           strobes,
  output logic [MUXA_W-1:0] select_mux_a,
  output logic [MUXB_W-1:0] select_mux_b,
  output logic [ALU_W-1:0]  alu_sel,
  output logic              halted
);

  strobe_t cw;

  always_comb begin
    cw           = '0;
    select_mux_a = '0;
    select_mux_b = '0;
    alu_sel      = '0;
    halted       = 1'b0;
    case (state)
      S_FETCH1: cw.write_iar = 1'b1;
      S_FETCH2: begin cw.inc_pc = 1'b1; cw.write_idr = 1'b1; end
      S_FETCH3: begin cw.write_iar = 1'b1; cw.write_ir = 1'b1; end
      S_LDAC1, S_STAC1: begin
        cw.inc_pc    = 1'b1;
        cw.inc_iar   = 1'b1;
        cw.write_idr = 1'b1;
      end
      S_LDAC2, S_STAC2: begin
        cw.inc_pc    = 1'b1;
        cw.write_idr = 1'b1;
        cw.write_tr  = 1'b1;
      end
      S_LDAC3, S_STAC3: begin
        select_mux_a = MUXA_W'(MUXA_SEL1);
        select_mux_b = MUXB_W'(MUXB_SEL1);
        alu_sel      = ALU_W'(ALU_CAT);
      end
      S_LDAC4, S_STAC4: cw.write_mar = 1'b1;
      S_LDAC5: cw.write1_mdr = 1'b1;
      S_LDAC6: begin
        select_mux_a = MUXA_W'(MUXA_SEL2);
        alu_sel      = ALU_W'(ALU_PASS);
      end
      S_LDAC7: cw.write_ac = 1'b1;
      S_STAC5: begin
        select_mux_b  = MUXB_W'(MUXB_SEL2);
        alu_sel       = ALU_W'(ALU_PASS);
        cw.write2_mdr = 1'b1;
      end
      S_STAC6: cw.write_dram = 1'b1;
      S_ADD1: begin
        select_mux_a = MUXA_W'(MUXA_SEL2);
        select_mux_b = MUXB_W'(MUXB_SEL2);
        alu_sel      = ALU_W'(ALU_ADD);
      end
      S_ADD2: cw.write_ac = 1'b1;
      // A taken jump loads the PC; an untaken one skips the address word in two increments
      S_JMP1: begin
        if (taken) cw.write_pc = 1'b1;
        else       cw.inc_pc   = 1'b1;
      end
      S_JMP2: cw.inc_pc = 1'b1;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign strobes = step ? cw : '0;

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - control unit FSM and retired-instruction counter; CU_SINGLE_STEP_EN adds step
module control_unit
  import cu_pkg::*;
#(
  parameter int IR_W   = 9,
  parameter int OPC_W  = 8,
  parameter int MUXA_W = 4,
  parameter int MUXB_W = 2,
  parameter int ALU_W  = 4,
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CU_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [IR_W-1:0]   dout_ir,
  input  logic              zero,
  input  logic              neg,
  input  logic              lsb,
  output logic              inc_pc,
  output logic              write_pc,
  output logic              write_iar,
  output logic              inc_iar,
  output logic              write_idr,
  output logic              write_ir,
  output logic              write_tr,
  output logic              write_mar,
  output logic              write_dram,
  output logic              off_dram,
  output logic              write1_mdr,
  output logic              write2_mdr,
  output logic              write_ac,
  output logic [MUXA_W-1:0] select_mux_a,
  output logic [MUXB_W-1:0] select_mux_b,
  output logic [ALU_W-1:0]  alu_sel,
  output logic              halted,
  output logic [ICNT_W-1:0] instr_count
);

  logic [ST_W-1:0]  state;
  logic [ST_W-1:0]  state_next;
  logic [OPC_W-1:0] opcode;
  logic             retire;
  logic             jmp_neg;
  logic             taken;
  logic             advance;
  logic             unused_inputs;
  strobe_t          strobes;

  assign opcode        = dout_ir[OPC_W-1:0];
  assign unused_inputs = ^{lsb, dout_ir[IR_W-1:OPC_W]};
  assign taken         = jmp_neg ? neg : zero;

`ifdef CU_SINGLE_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  // retire marks the last cycle of an instruction, including the entry into HALT
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_FETCH1: state_next = S_FETCH2;
      S_FETCH2: state_next = S_FETCH3;
      S_FETCH3: state_next = S_FETCH4;
      S_FETCH4: begin
        case (opcode)
          OPC_W'(OP_LDAC): state_next = S_LDAC1;
          OPC_W'(OP_STAC): state_next = S_STAC1;
          OPC_W'(OP_ADD):  state_next = S_ADD1;
          OPC_W'(OP_JMPZ),
          OPC_W'(OP_JMPN): state_next = S_JMP1;
          OPC_W'(OP_HALT): begin state_next = S_HALT; retire = 1'b1; end
          default:         begin state_next = S_FETCH1; retire = 1'b1; end
        endcase
      end
      S_LDAC1: state_next = S_LDAC2;
      S_LDAC2: state_next = S_LDAC3;
      S_LDAC3: state_next = S_LDAC4;
      S_LDAC4: state_next = S_LDAC5;
      S_LDAC5: state_next = S_LDAC6;
      S_LDAC6: state_next = S_LDAC7;
      S_STAC1: state_next = S_STAC2;
      S_STAC2: state_next = S_STAC3;
      S_STAC3: state_next = S_STAC4;
      S_STAC4: state_next = S_STAC5;
      S_STAC5: state_next = S_STAC6;
      S_ADD1:  state_next = S_ADD2;
      S_LDAC7, S_STAC6, S_ADD2, S_JMP2: begin
        state_next = S_FETCH1;
        retire     = 1'b1;
      end
      S_JMP1: begin
        state_next = taken ? S_FETCH1 : S_JMP2;
        retire     = taken;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH1;
      instr_count <= '0;
      jmp_neg     <= 1'b0;
    end else if (advance) begin
      state <= state_next;
      if (retire) instr_count <= instr_count + ICNT_W'(1);
      if (state == S_FETCH4) jmp_neg <= (opcode == OPC_W'(OP_JMPN));
    end
  end

  cu_decode #(
    .MUXA_W (MUXA_W),
    .MUXB_W (MUXB_W),
    .ALU_W  (ALU_W)
  ) u_decode (
    .state        (state),
    .taken        (taken),
    .step         (advance),
    .strobes      (strobes),
    .select_mux_a (select_mux_a),
    .select_mux_b (select_mux_b),
    .alu_sel      (alu_sel),
    .halted       (halted)
  );

  assign inc_pc     = strobes.inc_pc;
  assign write_pc   = strobes.write_pc;
  assign write_iar  = strobes.write_iar;
  assign inc_iar    = strobes.inc_iar;
  assign write_idr  = strobes.write_idr;
  assign write_ir   = strobes.write_ir;
  assign write_tr   = strobes.write_tr;
  assign write_mar  = strobes.write_mar;
  assign write_dram = strobes.write_dram;
  assign off_dram   = strobes.off_dram;
  assign write1_mdr = strobes.write1_mdr;
  assign write2_mdr = strobes.write2_mdr;
  assign write_ac   = strobes.write_ac;

endmodule
